// File: rtl/accumulator_pkg.sv
// accumulator_pkg
//   Shared definitions for the accumulator slice.
//   WIDTH_DEF : default data/accumulator width in bits
//   data_t    : signed two's-complement sample of WIDTH_DEF bits
package accumulator_pkg;

    localparam int WIDTH_DEF = 8;

    typedef logic signed [WIDTH_DEF-1:0] data_t;

endpackage : accumulator_pkg

// File: rtl/accumulator_add.sv
// accumulator_add
//   Combinational signed adder with wrap-around and signed-overflow flag.
//   Ports:
//     a   (in,  WIDTH) signed operand (current running sum)
//     b   (in,  WIDTH) signed operand (addend)
//     sum (out, WIDTH) a + b truncated to WIDTH bits (modulo 2^WIDTH)
//     ovf (out, 1)     1 when a and b share a sign and sum has the other sign
module accumulator_add
    import accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);

    // Overflow can only happen when both operands have the same sign and
    // the truncated result flips to the opposite sign.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    always_comb begin
        sum = a + b;
        ovf = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
    end

endmodule : accumulator_add

// File: rtl/accumulator.sv
// accumulator
//   Signed running-sum accumulator, one-cycle latency, wrap-around arithmetic.
//   Every rising clk edge (rst low) loads s + in; no enable, in = 0 holds.
//   Ports (order fixed so the first three can be hooked up positionally):
//     s   (out, WIDTH) registered signed running sum
//     clk (in,  1)     rising-edge clock
//     in  (in,  WIDTH) signed addend, sampled only at the rising edge
//     rst (in,  1)     asynchronous active-high reset, clears s and ovf
//     ovf (out, 1)     registered, non-sticky flag: last accumulation overflowed
module accumulator
    import accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    output logic signed [WIDTH-1:0] s,
    input  logic                    clk,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    rst,
    output logic                    ovf
);

    logic signed [WIDTH-1:0] sum_p0;
    logic                    ovf_p0;
    logic signed [WIDTH-1:0] s_p1;
    logic                    ovf_p1;

    // Stage p0: combinational add of the held sum and the incoming addend
    accumulator_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (s_p1),
        .b   (in),
        .sum (sum_p0),
        .ovf (ovf_p0)
    );

    // Stage p1: state register; outputs come straight from these flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_p1   <= '0;
            ovf_p1 <= 1'b0;
        end else begin
            s_p1   <= sum_p0;
            ovf_p1 <= ovf_p0;
        end
    end

    assign s   = s_p1;
    assign ovf = ovf_p1;

endmodule : accumulator

// File: tb/tb_accumulator.sv
// tb_accumulator
//   Self-checking bench for accumulator: directed cases followed by random
//   addends and random reset pulses, compared with an integer reference model.
module tb_accumulator;
    import accumulator_pkg::*;

    localparam int W    = WIDTH_DEF;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic                clk;
    logic                rst;
    logic signed [W-1:0] in;
    logic signed [W-1:0] s;
    logic                ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers
    int m_s   = 0;
    int m_ovf = 0;

    accumulator #(
        .WIDTH (W)
    ) dut (
        .s   (s),
        .clk (clk),
        .in  (in),
        .rst (rst),
        .ovf (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reduce an arbitrary integer into the signed W-bit range (mod 2^W)
    function automatic int wrap(input int v);
        int m;
        int r;
        m = 1 << W;
        r = v % m;
        if (r < 0) r += m;
        if (r > MAXV) r -= m;
        return r;
    endfunction

    function automatic int to_int(input logic signed [W-1:0] v);
        int r;
        r = v;
        return r;
    endfunction

    task automatic check(input string tag);
        int got_s;
        int got_o;
        got_s = to_int(s);
        got_o = (ovf === 1'b1) ? 1 : ((ovf === 1'b0) ? 0 : -1);
        total++;
        assert (got_s === m_s && !$isunknown(s))
        else begin
            bad++;
            $error("FAIL %s s: got %0d required %0d", tag, got_s, m_s);
        end
        total++;
        assert (got_o === m_ovf)
        else begin
            bad++;
            $error("FAIL %s ovf: got %0d required %0d", tag, got_o, m_ovf);
        end
    endtask

    // Apply one addend across one rising edge; model from plain arithmetic
    task automatic step(input int val, input string tag);
        int full;
        in = val[W-1:0];
        @(posedge clk);
        #1;
        full  = m_s + wrap(val);
        m_ovf = (full > MAXV || full < MINV) ? 1 : 0;
        m_s   = wrap(full);
        check(tag);
    endtask

    // Pulse rst between edges; outputs must clear before the next edge
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m_s   = 0;
        m_ovf = 0;
        check(tag);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int val;
        int pick;
        rst = 1'b0;
        in  = '0;
        #2;
        rst = 1'b1;
        #1;
        check("por_reset");

        // Edges while rst is high must not accumulate
        in = 8'sd33;
        @(posedge clk);
        #1;
        check("reset_hold_edge");
        #3;
        rst = 1'b0;
        #1;

        // Basic sequence and both overflow directions
        step(10,  "basic_10");
        step(20,  "basic_30");
        step(127, "pos_ovf");
        step(-50, "neg_ovf");

        // Hold with glitches on in between edges
        for (int k = 0; k < 3; k++) begin
            in = 8'sd0;
            #2;
            in = 8'sd77;
            #1;
            in = -8'sd100;
            #1;
            check("glitch_mid_cycle");
            in = 8'sd0;
            step(0, "hold_zero");
        end

        // Asynchronous reset with a nonzero sum
        reset_pulse("reset_nonzero");

        // Boundaries: max+1 -> min, min-1 -> max, max+min -> -1
        step(MAXV, "load_max");
        step(1,    "max_plus_1");
        step(-1,   "min_minus_1");
        step(MINV, "max_plus_min");

        // Mid-run reset discards the partial sum
        reset_pulse("reset_before_55");
        step(55, "load_55");
        reset_pulse("mid_run_reset");
        step(5, "after_reset_5");

        // Random addends biased towards the extremes, with random resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset_pulse("rand_reset");
            end else begin
                pick = $urandom_range(0, 7);
                case (pick)
                    0:       val = MAXV;
                    1:       val = MINV;
                    2:       val = -1;
                    3:       val = 1;
                    default: val = $urandom_range(0, (1 << W) - 1) + MINV;
                endcase
                step(val, "rand_step");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_accumulator
